// File: rtl/eth_axil_pkg.sv
// Shared definitions for the Ethernet AXI-Lite control/status register slave:
// response codes, fixed register indices, FSM state types and address decode.
package eth_axil_pkg;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   localparam int unsigned REG_CTRL    = 32'd0;
   localparam int unsigned REG_STATUS  = 32'd1;

   // Decode result is wide enough for any practical register count; callers
   // keep only the low $clog2(NUM_REGS) bits of the index.
   localparam int unsigned DEC_IDX_W   = 32'd16;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   typedef struct packed {
      logic                 valid;
      logic [DEC_IDX_W-1:0] idx;
   } dec_t;

   // Word-aligned and inside the bank (all upper address bits zero) is valid.
   function automatic dec_t addr_decode(input logic [63:0] addr,
                                        input int unsigned num_regs);
      dec_t d;
      d.valid = (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(num_regs));
      d.idx   = DEC_IDX_W'(addr >> 2);
      return d;
   endfunction

endpackage

// File: rtl/eth_axil_reg_slave.sv
// AXI-Lite slave exposing the Ethernet control/status register bank.
// Independent write and read FSMs share one register array; reg 0 drives the
// MAC control word, reg 1 reflects the live MAC status word, the rest are
// scratch registers.
module eth_axil_reg_slave
   import eth_axil_pkg::*;
#(
   parameter int unsigned              AXI_ADDR_WIDTH = 32,
   parameter int unsigned              AXI_DATA_WIDTH = 32,
   parameter int unsigned              NUM_REGS       = 8,
   parameter logic [AXI_DATA_WIDTH-1:0] CTRL_RESET    = '0
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
   input  logic                          awvalid,
   output logic                          awready,
   input  logic [AXI_DATA_WIDTH-1:0]     wdata,
   input  logic                          wlast,
   input  logic                          wvalid,
   output logic                          wready,
   output logic [1:0]                    bresp,
   output logic                          bvalid,
   input  logic                          bready,
   input  logic [AXI_ADDR_WIDTH-1:0]     araddr,
   input  logic                          arvalid,
   output logic                          arready,
   output logic [AXI_DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                    rresp,
   output logic                          rlast,
   output logic                          rvalid,
   input  logic                          rready,
   input  logic [AXI_DATA_WIDTH-1:0]     status_i,
   output logic [AXI_DATA_WIDTH-1:0]     ctrl_o,
   output logic                          reg_wr_pulse_o,
   output logic [$clog2(NUM_REGS)-1:0]   reg_wr_idx_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   wr_state_t                 r_wr_state;
   rd_state_t                 r_rd_state;
   logic                      r_awready;
   logic                      r_wready;
   logic                      r_arready;
   logic                      r_aw_got;
   logic                      r_w_got;
   logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
   logic [AXI_DATA_WIDTH-1:0] r_wdata;
   logic                      r_bvalid;
   logic [1:0]                r_bresp;
   logic                      r_rvalid;
   logic [1:0]                r_rresp;
   logic [AXI_DATA_WIDTH-1:0] r_rdata;
   logic                      r_wr_pulse;
   logic [IDX_W-1:0]          r_wr_idx;
   logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];

   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_have_aw;
   logic                      w_have_w;
   logic [AXI_ADDR_WIDTH-1:0] w_wr_addr;
   logic [AXI_DATA_WIDTH-1:0] w_wr_data;
   dec_t                      w_wr_dec;
   dec_t                      w_rd_dec;
   logic [IDX_W-1:0]          w_wr_idx;
   logic [IDX_W-1:0]          w_rd_idx;
   logic                      w_wr_en;
   logic [AXI_DATA_WIDTH-1:0] w_rd_val;
   logic [1:0]                w_rd_resp;
   logic                      w_unused;

   // Handshake detection, capture muxing and address decode for both channels.
   always_comb begin
      w_aw_hs   = awvalid && r_awready;
      w_w_hs    = wvalid && r_wready;
      w_have_aw = r_aw_got || w_aw_hs;
      w_have_w  = r_w_got || w_w_hs;
      w_wr_addr = w_aw_hs ? awaddr : r_awaddr;
      w_wr_data = w_w_hs ? wdata : r_wdata;
      w_wr_dec  = addr_decode(64'(w_wr_addr), NUM_REGS);
      w_rd_dec  = addr_decode(64'(araddr), NUM_REGS);
      w_wr_idx  = w_wr_dec.idx[IDX_W-1:0];
      w_rd_idx  = w_rd_dec.idx[IDX_W-1:0];
      // STATUS is read-only: writes are acknowledged but never land.
      w_wr_en   = w_wr_dec.valid && (w_wr_idx != IDX_W'(REG_STATUS));
      if (!w_rd_dec.valid) begin
         w_rd_val  = '0;
         w_rd_resp = RESP_SLVERR;
      end else if (w_rd_idx == IDX_W'(REG_STATUS)) begin
         w_rd_val  = status_i;
         w_rd_resp = RESP_OKAY;
      end else begin
         w_rd_val  = r_regs[w_rd_idx];
         w_rd_resp = RESP_OKAY;
      end
      w_unused  = ^{wlast, w_wr_dec.idx[DEC_IDX_W-1:IDX_W], w_rd_dec.idx[DEC_IDX_W-1:IDX_W]};
   end

   // Write FSM: collect AW and W in any order, commit, then hold B until accepted.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_wr_state <= W_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_aw_got   <= 1'b0;
         r_w_got    <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= 1'b0;
         r_wr_idx   <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_regs[i] <= (i == int'(REG_CTRL)) ? CTRL_RESET : '0;
         end
      end else begin
         r_wr_pulse <= 1'b0;
         case (r_wr_state)
            W_IDLE: begin
               if (w_have_aw && w_have_w) begin
                  if (w_wr_en) begin
                     r_regs[w_wr_idx] <= w_wr_data;
                     r_wr_pulse       <= 1'b1;
                     r_wr_idx         <= w_wr_idx;
                  end
                  r_bresp    <= w_wr_dec.valid ? RESP_OKAY : RESP_SLVERR;
                  r_bvalid   <= 1'b1;
                  r_awready  <= 1'b0;
                  r_wready   <= 1'b0;
                  r_aw_got   <= 1'b0;
                  r_w_got    <= 1'b0;
                  r_wr_state <= W_RESP;
               end else begin
                  r_aw_got  <= w_have_aw;
                  r_w_got   <= w_have_w;
                  r_awready <= !w_have_aw;
                  r_wready  <= !w_have_w;
                  r_awaddr  <= w_wr_addr;
                  r_wdata   <= w_wr_data;
               end
            end
            W_RESP: begin
               if (bready) begin
                  r_bvalid   <= 1'b0;
                  r_awready  <= 1'b1;
                  r_wready   <= 1'b1;
                  r_wr_state <= W_IDLE;
               end
            end
            default: begin
               r_wr_state <= W_IDLE;
               r_bvalid   <= 1'b0;
               r_awready  <= 1'b0;
               r_wready   <= 1'b0;
            end
         endcase
      end
   end

   // Read FSM: capture data at the AR handshake and hold it until R is accepted.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_rd_state <= R_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= '0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (!r_arready) begin
                  r_arready <= 1'b1;
               end else if (arvalid) begin
                  r_rdata    <= w_rd_val;
                  r_rresp    <= w_rd_resp;
                  r_rvalid   <= 1'b1;
                  r_arready  <= 1'b0;
                  r_rd_state <= R_DATA;
               end
            end
            R_DATA: begin
               if (rready) begin
                  r_rvalid   <= 1'b0;
                  r_arready  <= 1'b1;
                  r_rd_state <= R_IDLE;
               end
            end
            default: begin
               r_rd_state <= R_IDLE;
               r_rvalid   <= 1'b0;
               r_arready  <= 1'b0;
            end
         endcase
      end
   end

   assign awready        = r_awready;
   assign wready         = r_wready;
   assign bvalid         = r_bvalid;
   assign bresp          = r_bresp;
   assign arready        = r_arready;
   assign rvalid         = r_rvalid;
   assign rlast          = r_rvalid;
   assign rresp          = r_rresp;
   assign rdata          = r_rdata;
   assign ctrl_o         = r_regs[REG_CTRL];
   assign reg_wr_pulse_o = r_wr_pulse;
   assign reg_wr_idx_o   = r_wr_idx;

endmodule
